// File: rtl/uiicmp_echo_tx_q.sv
// uiicmp_echo_tx_q: queued ICMP echo-reply transmitter with incremental checksum rewrite.
// Define ICMP_TX_TIMEOUT_EN to abandon replies that wait too long for an ip_send grant.
module uiicmp_echo_tx_q #(
  parameter int LEN_W          = 11,
  parameter int MAX_PAYLOAD    = 1472,
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_icmp_req_en,
  input  logic [15:0]      I_icmp_req_id,
  input  logic [15:0]      I_icmp_req_sq_num,
  input  logic [15:0]      I_icmp_req_checksum,
  input  logic [31:0]      I_icmp_req_ip_addr,
  input  logic [LEN_W-1:0] I_icmp_ping_echo_data_len,
  input  logic [7:0]       I_icmp_ping_echo_data,
  output logic             O_icmp_ping_echo_ren,
  input  logic             I_icmp_pkg_busy,
  output logic             O_icmp_pkg_req,
  output logic             O_icmp_pkg_valid,
  output logic [7:0]       O_icmp_pkg_data,
  output logic             O_icmp_pkg_last,
  output logic [LEN_W-1:0] O_icmp_pkg_data_len,
  output logic [31:0]      O_icmp_pkg_ip_addr,
  output logic             O_icmp_req_drop,
  output logic             O_icmp_timeout
);

  localparam int PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  if ((REQ_DEPTH < 2) || (REQ_DEPTH > 16) || ((REQ_DEPTH & (REQ_DEPTH - 1)) != 0) ||
      (MAX_PAYLOAD > (2 ** LEN_W) - 9) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("uiicmp_echo_tx_q: illegal parameter combination");
  end

  logic [15:0]      id_mem_q  [REQ_DEPTH];
  logic [15:0]      sq_mem_q  [REQ_DEPTH];
  logic [15:0]      cks_mem_q [REQ_DEPTH];
  logic [31:0]      ip_mem_q  [REQ_DEPTH];
  logic [LEN_W-1:0] len_mem_q [REQ_DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, accept, push, pop;
  logic          drop_q;

  logic [16:0] cks_sum;
  logic [15:0] cks_fold, cks_new;

  logic [2:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d, hdr_idx;
  logic [LEN_W-1:0] pcnt_q, pcnt_d, rcnt_q, rcnt_d;
  logic [7:0]       data_q, data_d, hdr_byte;
  logic             valid_q, valid_d, last_q, last_d, req_q, req_d, ren_q, ren_d;
  logic             timeout_q, timeout_d;

  logic [15:0]      head_id, head_sq, head_cks;
  logic [31:0]      head_ip;
  logic [LEN_W-1:0] head_len;

  assign full   = (count_q == CW'(REQ_DEPTH));
  assign empty  = (count_q == '0);
  assign accept = !full && (I_icmp_ping_echo_data_len <= LEN_W'(MAX_PAYLOAD));
  assign push   = I_icmp_req_en && accept;

  // Type 8 -> 0 changes one checksummed word by -0x0800, hence the ~0x0800 addend.
  always_comb begin
    cks_sum  = {1'b0, ~I_icmp_req_checksum} + 17'h0F7FF;
    cks_fold = cks_sum[15:0] + {15'd0, cks_sum[16]};
    cks_new  = ~cks_fold;
  end

  always_ff @(posedge I_clk) begin
    if (push) begin
      id_mem_q[wr_ptr_q]  <= I_icmp_req_id;
      sq_mem_q[wr_ptr_q]  <= I_icmp_req_sq_num;
      cks_mem_q[wr_ptr_q] <= cks_new;
      ip_mem_q[wr_ptr_q]  <= I_icmp_req_ip_addr;
      len_mem_q[wr_ptr_q] <= I_icmp_ping_echo_data_len;
    end
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      drop_q  <= I_icmp_req_en && !accept;
    end
  end

  assign head_id  = id_mem_q[rd_ptr_q];
  assign head_sq  = sq_mem_q[rd_ptr_q];
  assign head_cks = cks_mem_q[rd_ptr_q];
  assign head_ip  = ip_mem_q[rd_ptr_q];
  assign head_len = len_mem_q[rd_ptr_q];

  assign hdr_idx = cnt_q + 3'd1;

  always_comb begin
    case (hdr_idx)
      3'd2:    hdr_byte = head_cks[15:8];
      3'd3:    hdr_byte = head_cks[7:0];
      3'd4:    hdr_byte = head_id[15:8];
      3'd5:    hdr_byte = head_id[7:0];
      3'd6:    hdr_byte = head_sq[15:8];
      3'd7:    hdr_byte = head_sq[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

`ifdef ICMP_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
  logic          tcnt_expired;

  assign tcnt_expired = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge I_clk) begin
    if (I_reset || (state_q != S_REQ)) tcnt_q <= '0;
    else                               tcnt_q <= tcnt_q + TW'(1);
  end
`endif

  // Registered outputs throughout; ren runs ahead of the byte stream by two cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    rcnt_d    = rcnt_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    req_d     = 1'b0;
    ren_d     = 1'b0;
    timeout_d = 1'b0;
    pop       = 1'b0;
    if (ren_q && (rcnt_q < head_len)) begin
      ren_d  = 1'b1;
      rcnt_d = rcnt_q + LEN_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_REQ;
          req_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (I_icmp_pkg_busy) begin
          valid_d = 1'b1;
          cnt_d   = 3'd0;
          state_d = S_HDR;
        end
`ifdef ICMP_TX_TIMEOUT_EN
        else if (tcnt_expired) begin
          timeout_d = 1'b1;
          if (head_len != '0) begin
            ren_d   = 1'b1;
            rcnt_d  = LEN_W'(1);
            state_d = S_FLUSH;
          end else begin
            state_d = S_DONE;
          end
        end
`endif
        else begin
          req_d = 1'b1;
        end
      end
      S_HDR: begin
        if (last_q) begin
          state_d = S_DONE;
        end else if (cnt_q == 3'd7) begin
          data_d  = I_icmp_ping_echo_data;
          valid_d = 1'b1;
          last_d  = (head_len == LEN_W'(1));
          pcnt_d  = '0;
          state_d = S_PAYLOAD;
        end else begin
          cnt_d   = hdr_idx;
          data_d  = hdr_byte;
          valid_d = 1'b1;
          last_d  = (hdr_idx == 3'd7) && (head_len == '0);
          if ((hdr_idx == 3'd6) && (head_len != '0)) begin
            ren_d  = 1'b1;
            rcnt_d = LEN_W'(1);
          end
        end
      end
      S_PAYLOAD: begin
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          data_d  = I_icmp_ping_echo_data;
          valid_d = 1'b1;
          pcnt_d  = pcnt_q + LEN_W'(1);
          last_d  = (({1'b0, pcnt_q} + (LEN_W + 1)'(2)) == {1'b0, head_len});
        end
      end
      S_FLUSH: begin
        if (rcnt_q >= head_len) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      rcnt_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      req_q     <= 1'b0;
      ren_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      rcnt_q    <= rcnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      req_q     <= req_d;
      ren_q     <= ren_d;
      timeout_q <= timeout_d;
    end
  end

  assign O_icmp_ping_echo_ren = ren_q;
  assign O_icmp_pkg_req       = req_q;
  assign O_icmp_pkg_valid     = valid_q;
  assign O_icmp_pkg_data      = data_q;
  assign O_icmp_pkg_last      = last_q;
  assign O_icmp_pkg_data_len  = empty ? '0 : (head_len + LEN_W'(8));
  assign O_icmp_pkg_ip_addr   = empty ? '0 : head_ip;
  assign O_icmp_req_drop      = drop_q;
`ifdef ICMP_TX_TIMEOUT_EN
  assign O_icmp_timeout       = timeout_q;
`else
  assign O_icmp_timeout       = 1'b0;
`endif

endmodule

// File: doc/uiicmp_echo_tx_q.md
Name: uiicmp_echo_tx_q

Overview:
- Parametrised ICMP echo-reply transmit engine; successor to the single-shot ICMP echo TX block.
- Queues up to REQ_DEPTH pending echo requests from the ICMP RX parser.
- Regenerates the reply checksum (type 8 -> 0) incrementally.
- Streams each reply (8-byte header + payload read from the echo-data FIFO) to ip_send with valid/last framing.
- Sits between the ICMP RX parser / echo-data FIFO and the ip_send arbiter.

Parameters:
- LEN_W, 11: width of payload-length fields.
- MAX_PAYLOAD, 1472: largest accepted payload in bytes; must be at most 2^LEN_W-9.
- REQ_DEPTH, 4: request queue entries; power of two, 2..16.
- TIMEOUT_CYCLES, 65535: cycles in REQ before abandoning a reply. Used only with ICMP_TX_TIMEOUT_EN.

Ports:
- I_clk  in  1  clock.
- I_reset  in  1  synchronous, active-high reset.
- I_icmp_req_en  in  1  one-cycle strobe: request fields valid.
- I_icmp_req_id  in  16  request identifier.
- I_icmp_req_sq_num  in  16  request sequence number.
- I_icmp_req_checksum  in  16  checksum field of the received echo request.
- I_icmp_req_ip_addr  in  32  remote IP address.
- I_icmp_ping_echo_data_len  in  LEN_W  payload byte count.
- I_icmp_ping_echo_data  in  8  echo FIFO data; valid the cycle after ren.
- O_icmp_ping_echo_ren  out  1  echo FIFO read enable.
- I_icmp_pkg_busy  in  1  ip_send grant/busy.
- O_icmp_pkg_req  out  1  transmit request.
- O_icmp_pkg_valid  out  1  byte valid.
- O_icmp_pkg_data  out  8  ICMP byte.
- O_icmp_pkg_last  out  1  final byte of frame.
- O_icmp_pkg_data_len  out  LEN_W  ICMP length = payload + 8.
- O_icmp_pkg_ip_addr  out  32  destination IP.
- O_icmp_req_drop  out  1  pulse: request rejected; upstream discards its payload.
- O_icmp_timeout  out  1  pulse: reply abandoned; compiled in by ICMP_TX_TIMEOUT_EN, otherwise tied 0.

Behaviour:
- Reset:
  - All outputs 0.
  - Queue empty, FSM in IDLE, counters 0.
  - Reset mid-frame aborts the frame immediately; no partial flush.
- Queue:
  - On I_icmp_req_en, if not full and len <= MAX_PAYLOAD, push {id, sq, cks', ip, len}.
  - Otherwise pulse O_icmp_req_drop for 1 cycle the following cycle and do not push.
  - Push and pop in the same cycle are both honoured; a full queue plus a same-cycle pop still rejects.
  - Pointers wrap modulo REQ_DEPTH.
- Checksum, computed at push time (RFC 1624 eq. 3):
  - s = ~C + 16'hF7FF (17-bit sum).
  - Fold the carry: s = s[15:0] + s[16].
  - cks' = ~s[15:0].
- Head outputs:
  - O_icmp_pkg_ip_addr and O_icmp_pkg_data_len are driven from the head entry.
  - Both are stable from the req rise through the last byte.
- FSM states: IDLE, REQ, HDR, PAYLOAD, FLUSH, DONE.
- IDLE: queue non-empty -> REQ; O_icmp_pkg_req=1 the next cycle.
- REQ:
  - Hold req until I_icmp_pkg_busy=1.
  - Then req=0, valid=1, data=8'h00 (type), -> HDR.
- HDR:
  - Bytes 1..7 in order: code 00, cks'[15:8], cks'[7:0], id[15:8], id[7:0], sq[15:8], sq[7:0].
  - valid is continuous.
  - ren rises together with the sq[15:8] byte when len > 0, so payload byte 0 is available for the following cycle.
  - len = 0: last=1 on the sq[7:0] byte -> DONE.
- PAYLOAD:
  - data = I_icmp_ping_echo_data each cycle, valid=1.
  - ren held high for exactly len cycles in total.
  - last=1 on payload byte len-1 -> DONE.
- Frame length: exactly 8 + len contiguous valid cycles; last is high on exactly one of them.
- DONE: valid=0, last=0, data=0; pop the head; -> IDLE. Gives a minimum 1-cycle gap between frames.
- FLUSH (timeout only):
  - ren=1 for len cycles with valid=0, discarding the payload.
  - Then pop and -> IDLE.
- I_icmp_req_en is accepted in every state, including during a frame.

Optional Feature:
- Macro: ICMP_TX_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ.
  - On reaching TIMEOUT_CYCLES with busy still 0: req=0, pulse O_icmp_timeout for 1 cycle.
  - -> FLUSH when len > 0, else -> DONE.
  - busy=1 on the terminal-count cycle takes priority (the frame is sent).
- Undefined: REQ waits indefinitely; O_icmp_timeout tied 0; no counter logic.

Test Plan:
- Single echo (id 16'h1234, sq 16'h0001, cks 16'h4D5A, ip C0A8_0102, len 4, payload 61 62 63 64); busy 3 cycles after req -> bytes 00 00 55 5A 12 34 00 01 61 62 63 64; last on 64; data_len=12; ren high 4 cycles.
- Checksum wrap: cks 16'hF7FE -> header bytes 2..3 = FF FE; len 0 -> 8-byte frame, last on sq low byte, ren never asserted.
- Back-to-back: 5 requests strobed on consecutive cycles, REQ_DEPTH=4 -> first 4 replied in order with gaps of at least 1 cycle; 5th gets O_icmp_req_drop one cycle after its strobe.
- Oversize: len=MAX_PAYLOAD+1 -> drop pulse; no req; queue unchanged.
- Reset asserted on payload byte 2 -> next cycle all outputs 0, queue empty; a fresh request then completes normally.
- ICMP_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, busy held 0, len 3 -> timeout pulse after 16 cycles in REQ, ren 3 cycles with valid 0, next queued request then served.
